// File: rtl/lock_pkg.sv
// Shared types for the lock controller: FSM state encoding and the op_mode bus values.
// The LOCKOUT state only exists when LOCKOUT_EN is defined.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SAVE_INIT = 3'd1,
      ST_OPEN      = 3'd2,
      ST_SAVE      = 3'd3,
      ST_DELETE    = 3'd4,
      ST_LOCKED    = 3'd5,
      ST_COMPARE   = 3'd6
`ifdef LOCKOUT_EN
      ,
      ST_LOCKOUT   = 3'd7
`endif
   } lock_state_e;

   typedef enum logic [1:0] {
      OP_STANDBY = 2'd0,
      OP_SAVE    = 2'd1,
      OP_DELETE  = 2'd2,
      OP_COMPARE = 2'd3
   } op_mode_e;

   // Which external engine a state is driving; standby for every waiting state.
   function automatic op_mode_e mode_of(input lock_state_e s);
      op_mode_e m;
      m = OP_STANDBY;
      case (s)
         ST_SAVE_INIT, ST_SAVE: m = OP_SAVE;
         ST_DELETE:             m = OP_DELETE;
         ST_COMPARE:            m = OP_COMPARE;
         default:               m = OP_STANDBY;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Up-counter with clear; done is asserted for the cycle in which the count sits at TERMINAL
// while enabled, so the caller can act on the same edge that would take it past TERMINAL.
module lock_timer #(
   parameter int           W        = 8,
   parameter logic [W-1:0] TERMINAL = '0
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != TERMINAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign done = en && !clr && (cnt_q == TERMINAL);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lock_controller_v2.sv
// PIN lock sequencer driving saver, deleter and comparator engines with auto-relock.
// Define LOCKOUT_EN to add a timed LOCKOUT state after MAX_FAIL consecutive mismatches.
module lock_controller_v2
   import lock_pkg::*;
#(
   parameter int PIN_LEN     = 4,
   parameter int CNT_W       = 3,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 1000,
   parameter int RELOCK_CYC  = 500
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enter,
   input  logic                          delete,
   input  logic                          lock,
   input  logic [CNT_W-1:0]              counter,
   input  logic                          saver_done,
   input  logic                          deleter_done,
   input  logic                          op_error,
   input  logic                          comparator_done,
   input  logic                          match,
   output logic                          save_start,
   output logic                          delete_start,
   output logic                          compare_start,
   output logic [1:0]                    op_mode,
   output logic                          unlock,
   output logic                          error,
   output logic                          locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
   output lock_state_e                   state_dbg
);

   localparam int FW          = $clog2(MAX_FAIL + 1);
   localparam int RELOCK_W    = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
   localparam int RELOCK_TERM = (RELOCK_CYC > 0) ? RELOCK_CYC - 1 : 0;

   lock_state_e state_q, state_d;
   op_mode_e    op_mode_q, op_mode_d;
   logic        save_start_q, save_start_d;
   logic        delete_start_q, delete_start_d;
   logic        compare_start_q, compare_start_d;
   logic        unlock_q, unlock_d;
   logic        error_q, error_d;
   logic [FW-1:0] fail_cnt_q, fail_cnt_d;

   logic pin_ok;
   logic in_open;
   logic relock_clr;
   logic relock_tc;
   logic relock_fire;

   assign pin_ok  = (counter == CNT_W'(PIN_LEN));
   assign in_open = (state_q == ST_OPEN);

   // Idle time in OPEN only; any user action there restarts it.
   assign relock_clr  = !in_open || enter || delete || lock;
   assign relock_fire = (RELOCK_CYC != 0) && relock_tc;

   lock_timer #(
      .W        (RELOCK_W),
      .TERMINAL (RELOCK_W'(RELOCK_TERM))
   ) u_relock_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (relock_clr),
      .en    (in_open),
      .done  (relock_tc)
   );

`ifdef LOCKOUT_EN
   localparam int LOCKOUT_W    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam int LOCKOUT_TERM = (LOCKOUT_CYC > 0) ? LOCKOUT_CYC - 1 : 0;

   logic in_lockout;
   logic lockout_tc;
   logic locked_out_q, locked_out_d;

   assign in_lockout = (state_q == ST_LOCKOUT);

   lock_timer #(
      .W        (LOCKOUT_W),
      .TERMINAL (LOCKOUT_W'(LOCKOUT_TERM))
   ) u_lockout_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (!in_lockout),
      .en    (in_lockout),
      .done  (lockout_tc)
   );
`endif

   // Handshake: a start is a level request raised on entry to the issuing state and held
   // until the engine answers with a one-cycle done; dones seen in any other state are dropped.
   always_comb begin
      state_d         = state_q;
      unlock_d        = 1'b0;
      error_d         = 1'b0;
      fail_cnt_d      = fail_cnt_q;
      save_start_d    = 1'b0;
      delete_start_d  = 1'b0;
      compare_start_d = 1'b0;
      op_mode_d       = OP_STANDBY;
`ifdef LOCKOUT_EN
      locked_out_d    = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (enter) begin
               if (pin_ok) begin
                  state_d = ST_SAVE_INIT;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_SAVE_INIT: begin
            if (saver_done) begin
               if (op_error) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_OPEN;
               end
            end
         end
         ST_OPEN: begin
            if (lock) begin
               state_d = ST_LOCKED;
            end else if (enter && delete) begin
               error_d = 1'b1;
            end else if ((enter || delete) && !pin_ok) begin
               error_d = 1'b1;
            end else if (enter) begin
               state_d = ST_SAVE;
            end else if (delete) begin
               state_d = ST_DELETE;
            end else if (relock_fire) begin
               state_d = ST_LOCKED;
            end
         end
         ST_SAVE: begin
            if (saver_done) begin
               error_d = op_error;
               state_d = ST_OPEN;
            end
         end
         ST_DELETE: begin
            if (deleter_done) begin
               error_d = op_error;
               state_d = ST_OPEN;
            end
         end
         ST_LOCKED: begin
            if (pin_ok) begin
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (comparator_done) begin
               if (match) begin
                  unlock_d   = 1'b1;
                  fail_cnt_d = '0;
                  state_d    = ST_OPEN;
               end else begin
                  error_d = 1'b1;
                  if (fail_cnt_q < FW'(MAX_FAIL)) begin
                     fail_cnt_d = fail_cnt_q + 1'b1;
                  end
                  state_d = ST_LOCKED;
`ifdef LOCKOUT_EN
                  if (fail_cnt_d == FW'(MAX_FAIL)) begin
                     state_d = ST_LOCKOUT;
                  end
`endif
               end
            end
         end
`ifdef LOCKOUT_EN
         ST_LOCKOUT: begin
            if (lockout_tc) begin
               fail_cnt_d = '0;
               state_d    = ST_LOCKED;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register together with it.
      op_mode_d       = mode_of(state_d);
      save_start_d    = (op_mode_d == OP_SAVE);
      delete_start_d  = (op_mode_d == OP_DELETE);
      compare_start_d = (op_mode_d == OP_COMPARE);
`ifdef LOCKOUT_EN
      locked_out_d    = (state_d == ST_LOCKOUT);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         op_mode_q       <= OP_STANDBY;
         save_start_q    <= 1'b0;
         delete_start_q  <= 1'b0;
         compare_start_q <= 1'b0;
         unlock_q        <= 1'b0;
         error_q         <= 1'b0;
         fail_cnt_q      <= '0;
`ifdef LOCKOUT_EN
         locked_out_q    <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         op_mode_q       <= op_mode_d;
         save_start_q    <= save_start_d;
         delete_start_q  <= delete_start_d;
         compare_start_q <= compare_start_d;
         unlock_q        <= unlock_d;
         error_q         <= error_d;
         fail_cnt_q      <= fail_cnt_d;
`ifdef LOCKOUT_EN
         locked_out_q    <= locked_out_d;
`endif
      end
   end

   assign save_start    = save_start_q;
   assign delete_start  = delete_start_q;
   assign compare_start = compare_start_q;
   assign op_mode       = op_mode_q;
   assign unlock        = unlock_q;
   assign error         = error_q;
   assign fail_cnt      = fail_cnt_q;
   assign state_dbg     = state_q;
`ifdef LOCKOUT_EN
   assign locked_out    = locked_out_q;
`else
   assign locked_out    = 1'b0;
`endif

endmodule
